// File: rtl/sys1_input_ctrl.sv
// sys1_input_ctrl: merges PS/2 keys and joysticks into active-low player/system ports,
// shapes coin pulses, and loads the DIP banks and SYSMODE over ioctl.
module sys1_input_ctrl #(
    parameter int         NPLAYER    = 2,
    parameter int         NDSW       = 8,
    parameter logic [7:0] DSW_IDX    = 8'd254,
    parameter logic [7:0] SYS_IDX    = 8'd1,
    parameter logic [7:0] DSW_DEF    = 8'hFF,
    parameter int         COIN_W     = 16,
    parameter int         COIN_GAP   = 16,
    parameter bit         SAMPLE_VBL = 1'b0
) (
    input  logic                  clk_sys_i,
    input  logic                  reset_n_i,
    input  logic [10:0]           ps2_key_i,
    input  logic [NPLAYER*16-1:0] joy_i,
    input  logic                  cocktail_i,
    input  logic                  vblank_i,
    input  logic                  ioctl_wr_i,
    input  logic [7:0]            ioctl_index_i,
    input  logic [24:0]           ioctl_addr_i,
    input  logic [7:0]            ioctl_dout_i,
    output logic [NPLAYER*8-1:0]  inp_o,
    output logic [7:0]            inp_sys_o,
    output logic [NDSW*8-1:0]     dsw_o,
    output logic [7:0]            sysmode_o
);
    localparam int CMAX = COIN_W > COIN_GAP ? COIN_W : COIN_GAP;
    localparam int CW   = $clog2(CMAX) + 1;
    localparam logic [CW-1:0] W_LD = CW'(COIN_W - 1);
    localparam logic [CW-1:0] G_LD = CW'(COIN_GAP - 1);

    typedef enum logic [1:0] {IDLE, PULSE, GAP} coin_st_t;

    // key button vectors are {L,R,U,D,trig2,trig1}
    logic                    toggle_q;
    logic [5:0]              key_p1_q, key_p1_d, key_p2_q, key_p2_d;
    logic [1:0]              key_st_q, key_st_d, key_coin_q, key_coin_d;
    logic [NPLAYER-1:0][5:0] btn;
    logic [NPLAYER*8-1:0]    inp_d, inp_q, stg_inp_q;
    logic [1:0]              st_d, st_q, stg_st_q;
    logic                    vbl_q, coin_req, coin_req_q, coin_rise, coin_q, pend_q;
    coin_st_t                coin_st_q;
    logic [CW-1:0]           cnt_q;
    logic [NDSW-1:0][7:0]    dsw_q;
    logic [7:0]              sysmode_q;
    logic                    unused;

    always_comb begin
        key_p1_d   = key_p1_q;
        key_p2_d   = key_p2_q;
        key_st_d   = key_st_q;
        key_coin_d = key_coin_q;
        if (ps2_key_i[10] != toggle_q) begin
            case (ps2_key_i[7:0])
                8'h6B: key_p1_d[5] = ps2_key_i[9];
                8'h74: key_p1_d[4] = ps2_key_i[9];
                8'h75: key_p1_d[3] = ps2_key_i[9];
                8'h72: key_p1_d[2] = ps2_key_i[9];
                8'h14: key_p1_d[1] = ps2_key_i[9];
                8'h29: key_p1_d[0] = ps2_key_i[9];
                8'h23: key_p2_d[5] = ps2_key_i[9];
                8'h34: key_p2_d[4] = ps2_key_i[9];
                8'h2D: key_p2_d[3] = ps2_key_i[9];
                8'h2B: key_p2_d[2] = ps2_key_i[9];
                8'h1B: key_p2_d[1] = ps2_key_i[9];
                8'h1C: key_p2_d[0] = ps2_key_i[9];
                8'h16: key_st_d[0] = ps2_key_i[9];
                8'h1E: key_st_d[1] = ps2_key_i[9];
                8'h2E: key_coin_d[0] = ps2_key_i[9];
                8'h36: key_coin_d[1] = ps2_key_i[9];
                8'h05: begin
                    key_st_d[0]   = ps2_key_i[9];
                    key_coin_d[0] = ps2_key_i[9];
                end
                8'h06: begin
                    key_st_d[1]   = ps2_key_i[9];
                    key_coin_d[1] = ps2_key_i[9];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        btn      = '0;
        inp_d    = '1;
        coin_req = |key_coin_q;
        for (int p = 0; p < NPLAYER; p++) begin
            btn[p] = {joy_i[16*p+1], joy_i[16*p], joy_i[16*p+3], joy_i[16*p+2], joy_i[16*p+5], joy_i[16*p+4]}
                   | (p == 0 ? key_p1_q : p == 1 ? key_p2_q : 6'd0);
            coin_req = coin_req | joy_i[16*p+8];
        end
        btn[0] = cocktail_i ? btn[0] : btn[0] | btn[1];
        for (int p = 0; p < NPLAYER; p++)
            inp_d[8*p +: 8] = ~{btn[p][5:2], 1'b0, btn[p][1:0], 1'b0};
    end

    assign st_d      = key_st_q | {joy_i[22], joy_i[6]};
    assign coin_rise = coin_req & ~coin_req_q;

    always_ff @(posedge clk_sys_i) begin
        if (!reset_n_i) begin
            toggle_q   <= 1'b0;
            key_p1_q   <= '0;
            key_p2_q   <= '0;
            key_st_q   <= '0;
            key_coin_q <= '0;
            inp_q      <= '1;
            stg_inp_q  <= '1;
            st_q       <= '0;
            stg_st_q   <= '0;
            vbl_q      <= 1'b0;
        end else begin
            toggle_q   <= ps2_key_i[10];
            key_p1_q   <= key_p1_d;
            key_p2_q   <= key_p2_d;
            key_st_q   <= key_st_d;
            key_coin_q <= key_coin_d;
            stg_inp_q  <= inp_d;
            stg_st_q   <= st_d;
            vbl_q      <= vblank_i;
            if (!SAMPLE_VBL) begin
                inp_q <= inp_d;
                st_q  <= st_d;
            end else if (vblank_i && !vbl_q) begin
                inp_q <= stg_inp_q;
                st_q  <= stg_st_q;
            end
        end
    end

    // coin timing is self-contained, so the pulse bypasses VBlank sampling
    always_ff @(posedge clk_sys_i) begin
        if (!reset_n_i) begin
            coin_st_q  <= IDLE;
            cnt_q      <= '0;
            coin_q     <= 1'b1;
            pend_q     <= 1'b0;
            coin_req_q <= 1'b0;
        end else begin
            coin_req_q <= coin_req;
            case (coin_st_q)
                IDLE: if (coin_rise) begin
                    coin_st_q <= PULSE;
                    cnt_q     <= W_LD;
                    coin_q    <= 1'b0;
                end
                PULSE: begin
                    if (coin_rise)
                        pend_q <= 1'b1;
                    if (cnt_q == '0) begin
                        coin_st_q <= GAP;
                        cnt_q     <= G_LD;
                        coin_q    <= 1'b1;
                    end else
                        cnt_q <= cnt_q - CW'(1);
                end
                GAP: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                        if (coin_rise)
                            pend_q <= 1'b1;
                    end else if (pend_q || coin_rise) begin
                        coin_st_q <= PULSE;
                        cnt_q     <= W_LD;
                        coin_q    <= 1'b0;
                        pend_q    <= 1'b0;
                    end else
                        coin_st_q <= IDLE;
                end
                default: coin_st_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys_i) begin
        if (!reset_n_i) begin
            dsw_q     <= {NDSW{DSW_DEF}};
            sysmode_q <= '0;
        end else if (ioctl_wr_i) begin
            for (int k = 0; k < NDSW; k++)
                if (ioctl_index_i == DSW_IDX && ioctl_addr_i == 25'(k))
                    dsw_q[k] <= ioctl_dout_i;
            if (ioctl_index_i == SYS_IDX && ioctl_addr_i == '0)
                sysmode_q <= ioctl_dout_i;
        end
    end

    assign inp_o     = inp_q;
    assign inp_sys_o = {2'b11, ~st_q, 3'b111, coin_q};
    assign dsw_o     = dsw_q;
    assign sysmode_o = sysmode_q;
    assign unused    = ^{ps2_key_i[8], joy_i};
endmodule

// File: tb/tb_sys1_input_ctrl.sv
// tb_sys1_input_ctrl: random and directed stimulus against a behavioural model of the input front end
module tb_sys1_input_ctrl;
    localparam int W = 4;
    localparam int G = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] ps2_key = '0;
    logic [31:0] joy = '0;
    logic        cocktail = 1'b0;
    logic        vblank = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [7:0]  ioctl_index = '0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic [15:0] inp, inpv;
    logic [7:0]  inp_sys, inp_sysv, sysmode, sysmodev;
    logic [63:0] dsw, dswv;

    sys1_input_ctrl #(.NPLAYER(2), .NDSW(8), .COIN_W(W), .COIN_GAP(G), .SAMPLE_VBL(1'b0)) dut (
        .clk_sys_i(clk), .reset_n_i(reset_n), .ps2_key_i(ps2_key), .joy_i(joy), .cocktail_i(cocktail),
        .vblank_i(vblank), .ioctl_wr_i(ioctl_wr), .ioctl_index_i(ioctl_index), .ioctl_addr_i(ioctl_addr),
        .ioctl_dout_i(ioctl_dout), .inp_o(inp), .inp_sys_o(inp_sys), .dsw_o(dsw), .sysmode_o(sysmode));

    sys1_input_ctrl #(.NPLAYER(2), .NDSW(8), .COIN_W(W), .COIN_GAP(G), .SAMPLE_VBL(1'b1)) dutv (
        .clk_sys_i(clk), .reset_n_i(reset_n), .ps2_key_i(ps2_key), .joy_i(joy), .cocktail_i(cocktail),
        .vblank_i(vblank), .ioctl_wr_i(ioctl_wr), .ioctl_index_i(ioctl_index), .ioctl_addr_i(ioctl_addr),
        .ioctl_dout_i(ioctl_dout), .inp_o(inpv), .inp_sys_o(inp_sysv), .dsw_o(dswv), .sysmode_o(sysmodev));

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    logic        held[256];
    logic        tog_m, vbl_m, req_m, pend_m;
    logic [15:0] exp_inp, stg_inp, expv_inp;
    logic [1:0]  exp_st, stg_st, expv_st;
    logic [7:0]  dsw_m[8];
    logic [7:0]  sys_m;
    int          cyc = 0;
    int          cs = -1000;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] joyb(input int p);
        return {joy[16*p+1], joy[16*p], joy[16*p+3], joy[16*p+2], joy[16*p+5], joy[16*p+4]};
    endfunction

    function automatic logic [7:0] pk(input logic [5:0] b);
        return ~{b[5:2], 1'b0, b[1:0], 1'b0};
    endfunction

    task automatic key(input logic [8:0] code, input logic pr);
        ps2_key = {~ps2_key[10], pr, code};
    endtask

    task automatic tick();
        logic [5:0]  b0, b1;
        logic [1:0]  st;
        logic [15:0] nxt;
        logic [63:0] dflat;
        logic        req, rise, low;
        if (!reset_n) begin
            foreach (held[i]) held[i] = 1'b0;
            foreach (dsw_m[i]) dsw_m[i] = 8'hFF;
            tog_m = 1'b0; vbl_m = 1'b0; req_m = 1'b0; pend_m = 1'b0; cs = -1000;
            exp_inp = '1; stg_inp = '1; expv_inp = '1;
            exp_st = '0; stg_st = '0; expv_st = '0; sys_m = '0;
        end else begin
            b1 = joyb(1) | {held['h23], held['h34], held['h2D], held['h2B], held['h1B], held['h1C]};
            b0 = joyb(0) | {held['h6B], held['h74], held['h75], held['h72], held['h14], held['h29]}
               | (cocktail ? 6'd0 : b1);
            nxt = {pk(b1), pk(b0)};
            st = {joy[22] | held['h1E] | held['h06], joy[6] | held['h16] | held['h05]};
            req = joy[8] | joy[24] | held['h2E] | held['h36] | held['h05] | held['h06];
            rise = req && !req_m;
            req_m = req;
            if (pend_m && cyc == cs + W + G) begin
                cs = cyc;
                pend_m = 1'b0;
            end else if (rise && cyc >= cs + W + G) cs = cyc;
            else if (rise) pend_m = 1'b1;
            if (vblank && !vbl_m) begin
                expv_inp = stg_inp;
                expv_st = stg_st;
            end
            vbl_m = vblank; stg_inp = nxt; stg_st = st; exp_inp = nxt; exp_st = st;
            if (ps2_key[10] != tog_m) held[ps2_key[7:0]] = ps2_key[9];
            tog_m = ps2_key[10];
            if (ioctl_wr && ioctl_index == 8'd254 && ioctl_addr < 25'd8) dsw_m[ioctl_addr[2:0]] = ioctl_dout;
            if (ioctl_wr && ioctl_index == 8'd1 && ioctl_addr == 25'd0) sys_m = ioctl_dout;
        end
        low = cyc >= cs && cyc < cs + W;
        for (int k = 0; k < 8; k++) dflat[8*k +: 8] = dsw_m[k];
        cyc++;
        @(posedge clk);
        #1;
        chk("inp", 64'(inp), 64'(exp_inp));
        chk("inp_sys", 64'(inp_sys), 64'({2'b11, ~exp_st, 3'b111, ~low}));
        chk("inp_vbl", 64'(inpv), 64'(expv_inp));
        chk("inp_sys_vbl", 64'(inp_sysv), 64'({2'b11, ~expv_st, 3'b111, ~low}));
        chk("dsw", dsw, dflat);
        chk("sysmode", 64'(sysmode), 64'(sys_m));
    endtask

    initial begin
        int          lows;
        logic [19:0] seq;
        logic [7:0]  codes[16] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h14, 8'h2D, 8'h2B,
                                   8'h23, 8'h34, 8'h1C, 8'h1B, 8'h16, 8'h1E, 8'h2E, 8'h36};
        repeat (3) tick();
        chk("rst_inp", 64'(inp), 64'h FFFF);
        chk("rst_sys", 64'(inp_sys), 64'hFF);
        chk("rst_dsw", dsw, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rst_sysmode", 64'(sysmode), 64'h0);
        reset_n = 1'b1;
        tick();
        key(9'h075, 1'b1);
        tick();
        chk("ps2_up_early", 64'(inp[5]), 64'h1);
        tick();
        chk("ps2_up_press", 64'(inp[5]), 64'h0);
        key(9'h075, 1'b0);
        repeat (2) tick();
        chk("ps2_up_release", 64'(inp[5]), 64'h1);
        joy[20] = 1'b1;
        tick();
        chk("ck0_p1", 64'(inp[1]), 64'h0);
        chk("ck0_p2", 64'(inp[9]), 64'h0);
        cocktail = 1'b1;
        tick();
        chk("ck1_p1", 64'(inp[1]), 64'h1);
        chk("ck1_p2", 64'(inp[9]), 64'h0);
        joy = '0;
        cocktail = 1'b0;
        tick();
        lows = 0;
        joy[8] = 1'b1;
        repeat (20) begin
            tick();
            lows += int'(!inp_sys[0]);
        end
        chk("coin_hold_width", 64'(lows), 64'd4);
        joy[8] = 1'b0;
        repeat (10) tick();
        for (int t = 0; t < 20; t++) begin
            joy[8] = (t == 0 || t == 2);
            tick();
            seq[t] = inp_sys[0];
        end
        chk("coin_two_press", 64'(seq), 64'hFF870);
        key(9'h005, 1'b1);
        repeat (2) tick();
        chk("f1_start1", 64'(inp_sys[4]), 64'h0);
        key(9'h005, 1'b0);
        repeat (12) tick();
        for (int a = 0; a < 9; a++) begin
            ioctl_wr = 1'b1;
            ioctl_index = 8'd254;
            ioctl_addr = 25'(a);
            ioctl_dout = 8'hA0 + 8'(a);
            tick();
        end
        ioctl_index = 8'd1;
        ioctl_addr = '0;
        ioctl_dout = 8'h05;
        tick();
        ioctl_wr = 1'b0;
        tick();
        chk("dip_load", dsw, 64'hA7A6_A5A4_A3A2_A1A0);
        chk("sysmode_load", 64'(sysmode), 64'h05);
        key(9'h029, 1'b1);
        repeat (4) tick();
        chk("vbl_hold", 64'(inpv[1]), 64'h1);
        vblank = 1'b1;
        tick();
        chk("vbl_load", 64'(inpv[1]), 64'h0);
        vblank = 1'b0;
        key(9'h029, 1'b0);
        repeat (3) tick();
        for (int i = 0; i < 800; i++) begin
            logic [7:0] c;
            if ($urandom_range(0, 2) == 0) joy = $urandom & $urandom & $urandom;
            if ($urandom_range(0, 3) == 0) begin
                c = $urandom_range(0, 7) == 0 ? 8'($urandom_range(7, 255)) : codes[$urandom_range(0, 15)];
                key({1'($urandom_range(0, 1)), c}, 1'($urandom_range(0, 1)));
            end
            if ($urandom_range(0, 9) == 0) cocktail = ~cocktail;
            if ($urandom_range(0, 5) == 0) vblank = ~vblank;
            ioctl_wr = $urandom_range(0, 3) == 0;
            ioctl_index = $urandom_range(0, 2) == 0 ? 8'd1 : $urandom_range(0, 1) == 0 ? 8'd254 : 8'd9;
            ioctl_addr = 25'($urandom_range(0, 10));
            ioctl_dout = 8'($urandom);
            reset_n = $urandom_range(0, 199) != 0;
            tick();
        end
        ioctl_wr = 1'b0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("final_rst_dsw", dsw, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("final_rst_sys", 64'(inp_sys), 64'hFF);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
